// File: rtl/fpu_mul_div_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fpu_ctrl_pkg
// Shared types and constants for the FP32 multiply/divide arbiter slice.
//   op_e        : operation select (multiply / divide)
//   fpu_flags_t : IEEE exception flags as reported by the unit
//   tag_t       : {valid, id} token that shadows each operation in flight
//   FP32_ONE/INF: frequently used single-precision encodings
// ---------------------------------------------------------------------------
package fpu_ctrl_pkg;

    // Wide enough for the largest supported requester count (8).
    localparam int TAG_ID_W = 3;

    localparam logic [31:0] FP32_ONE = 32'h3F80_0000;
    localparam logic [31:0] FP32_INF = 32'h7F80_0000;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    typedef struct packed {
        logic io;
        logic dz;
        logic of;
        logic uf;
        logic i;
    } fpu_flags_t;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Converts a loop index into a tag id without width surprises.
    function automatic logic [TAG_ID_W-1:0] toTagId(input int idx);
        return TAG_ID_W'(idx);
    endfunction

endpackage

// File: rtl/fpu_mul_div_arbiter_if.sv
// ---------------------------------------------------------------------------
// fpu_mul_div_arbiter_if
// Bundles the requester-side and unit-side signals of the arbiter.
//   req_valid/req_ready/req_a/req_b/req_sel : per-requester issue handshake
//   rsp_valid/rsp_ready/rsp_r/rsp_flags     : per-requester response handshake
//   fpu_a/fpu_b/fpu_sel/fpu_en/fpu_r/fpu_flags : shared mul/div datapath
//   inflight                                : operations issued, not retired
// Modports:
//   master : the environment (requesters plus the mul/div unit)
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface fpu_mul_div_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int FPU_LAT = 3
);
    import fpu_ctrl_pkg::*;

    localparam int INF_W = $clog2(FPU_LAT + 2);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ-1:0]    req_sel;

    logic [31:0]           fpu_a;
    logic [31:0]           fpu_b;
    logic                  fpu_sel;
    logic                  fpu_en;
    logic [31:0]           fpu_r;
    fpu_flags_t            fpu_flags;

    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [31:0]           rsp_r;
    fpu_flags_t            rsp_flags;

    logic [INF_W-1:0]      inflight;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready, fpu_r, fpu_flags,
        input  req_ready, fpu_a, fpu_b, fpu_sel, fpu_en,
               rsp_valid, rsp_r, rsp_flags, inflight
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready, fpu_r, fpu_flags,
        output req_ready, fpu_a, fpu_b, fpu_sel, fpu_en,
               rsp_valid, rsp_r, rsp_flags, inflight
    );

endinterface

// File: rtl/fpu_mul_div_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: grants the first requester at or after an internal
// pointer, then moves the pointer just past the winner.
//   clk, arst : clock, asynchronous active-low reset
//   i_req     : request vector
//   i_en      : arbitration enable; grant is forced to zero when low
//   o_grant   : one-hot grant (zero when nothing is requested or disabled)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         arst,
    input  logic [N-1:0] i_req,
    input  logic         i_en,
    output logic [N-1:0] o_grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [N-1:0]  w_pick;
    logic [PW-1:0] w_next;
    logic          w_found;

    // Two passes: first look at or above the pointer, then wrap to the
    // bottom. The first hit in that order is the round-robin winner.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[i] && (i >= int'(r_ptr))) begin
                w_found   = 1'b1;
                w_pick[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_req[i]) begin
                w_found   = 1'b1;
                w_pick[i] = 1'b1;
            end
        end
    end

    // Pointer target is the slot after the winner, wrapping at N.
    always_comb begin
        w_next = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (w_pick[i]) begin
                w_next = (i == N - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    assign o_grant = i_en ? w_pick : '0;

    // Pointer only moves when a grant actually goes out.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_ptr <= '0;
        end else if (i_en && (|i_req)) begin
            r_ptr <= w_next;
        end
    end

endmodule

// File: rtl/fpu_mul_div_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_mul_div_arbiter
// Shares one pipelined FP32 mul/div unit among NUM_REQ requesters. Winning
// operands are registered into the unit, a {valid,id} tag rides a shadow
// pipeline alongside, and the tail tag steers the unit's result back to the
// requester that issued it.
//   clk, arst : clock, asynchronous active-low reset
//   bus       : slave view of fpu_mul_div_arbiter_if
//               (requester issue/response handshakes, unit a/b/sel/en,
//                unit r/flags, inflight count)
// ---------------------------------------------------------------------------
module fpu_mul_div_arbiter
    import fpu_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int FPU_LAT = 3
) (
    input  logic                  clk,
    input  logic                  arst,
    fpu_mul_div_arbiter_if.slave  bus
);
    localparam int INF_W = $clog2(FPU_LAT + 2);

    logic                w_en;
    logic                w_stall;
    logic                w_tailReady;
    logic                w_issue;
    logic                w_retire;
    logic [NUM_REQ-1:0]  w_grant;
    logic [NUM_REQ-1:0]  w_rspValid;
    logic [TAG_ID_W-1:0] w_grantId;
    logic [31:0]         w_a;
    logic [31:0]         w_b;
    logic                w_sel;
    tag_t                w_tail;

    logic [31:0]         r_a;
    logic [31:0]         r_b;
    op_e                 r_sel;
    tag_t                r_tag [0:FPU_LAT];
    logic [INF_W-1:0]    r_inflight;

    // Tail stage lines up with the unit's result.
    assign w_tail = r_tag[FPU_LAT];

    // Decode the tail id into a response strobe and pick that requester's
    // ready; the id field is wider than NUM_REQ, so compare per slot.
    always_comb begin
        w_tailReady = 1'b0;
        w_rspValid  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_tail.id == toTagId(i)) begin
                w_tailReady   = bus.rsp_ready[i];
                w_rspValid[i] = w_tail.valid;
            end
        end
    end

    // A result waiting on a busy requester freezes everything behind it,
    // including the unit; reset also keeps the unit frozen.
    assign w_stall = w_tail.valid & ~w_tailReady;
    assign w_en    = arst & ~w_stall;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rrArbiter (
        .clk     (clk),
        .arst    (arst),
        .i_req   (bus.req_valid),
        .i_en    (w_en),
        .o_grant (w_grant)
    );

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_a       = '0;
        w_b       = '0;
        w_sel     = 1'b0;
        w_grantId = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_a       = bus.req_a[i*32 +: 32];
                w_b       = bus.req_b[i*32 +: 32];
                w_sel     = bus.req_sel[i];
                w_grantId = toTagId(i);
            end
        end
    end

    // The grant only ever covers a valid request, so any grant is a handshake.
    assign w_issue  = |w_grant;
    assign w_retire = |(w_rspValid & bus.rsp_ready);

    // Issue registers keep their last operands across bubbles; the tag
    // marks those cycles invalid so the stale data never reaches anyone.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sel <= OP_MUL;
        end else if (w_issue) begin
            r_a   <= w_a;
            r_b   <= w_b;
            r_sel <= op_e'(w_sel);
        end
    end

    // Shadow tag pipeline advances in lock-step with the unit.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int s = 0; s <= FPU_LAT; s++) begin
                r_tag[s] <= '0;
            end
        end else if (w_en) begin
            r_tag[0] <= tag_t'{valid: w_issue, id: w_grantId};
            for (int s = 1; s <= FPU_LAT; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    // Issue and retire in the same cycle cancel out.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_inflight <= '0;
        end else if (w_issue && !w_retire) begin
            r_inflight <= r_inflight + INF_W'(1);
        end else if (!w_issue && w_retire) begin
            r_inflight <= r_inflight - INF_W'(1);
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.fpu_a     = r_a;
    assign bus.fpu_b     = r_b;
    assign bus.fpu_sel   = r_sel;
    assign bus.fpu_en    = w_en;
    assign bus.rsp_valid = w_rspValid;
    assign bus.rsp_r     = bus.fpu_r;
    assign bus.rsp_flags = bus.fpu_flags;
    assign bus.inflight  = r_inflight;

endmodule

// File: tb/tb_fpu_mul_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fpu_mul_div_arbiter
// Drives the arbiter with directed and random operations, models the shared
// unit as a FPU_LAT-deep pipeline that freezes on fpu_en=0, and compares
// every cycle against a queue-based reference of outstanding operations.
// ---------------------------------------------------------------------------
module tb_fpu_mul_div_arbiter;
    import fpu_ctrl_pkg::*;

    localparam int N = 2;
    localparam int L = 3;

    logic clk  = 1'b0;
    logic arst = 1'b0;

    always #5 clk = ~clk;

    fpu_mul_div_arbiter_if #(.NUM_REQ(N), .FPU_LAT(L)) bus ();

    fpu_mul_div_arbiter #(.NUM_REQ(N), .FPU_LAT(L)) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    // Stand-in for the arithmetic: exact answers for the directed operand
    // pairs, a deterministic scramble for everything else.
    function automatic logic [36:0] unitOp(input logic [31:0] a, input logic [31:0] b,
                                           input logic sel);
        logic [31:0] lowB;
        lowB = b;
        if (!sel && a == 32'h4000_0000 && b == 32'h4040_0000) return {5'b00000, 32'h40C0_0000};
        if (sel && a == 32'h40C0_0000 && b == 32'h4000_0000)  return {5'b00000, 32'h4040_0000};
        if (!sel && a == FP32_ONE && b == FP32_ONE)           return {5'b00000, FP32_ONE};
        if (sel && lowB[30:0] == 31'd0)                       return {5'b01000, FP32_INF};
        return {a[4:0] ^ lowB[9:5], a ^ {lowB[15:0], lowB[31:16]} ^ {31'd0, sel}};
    endfunction

    // Behavioural unit: holds everything while fpu_en is low.
    logic [36:0] unitPipe [0:L-1];
    always @(posedge clk) begin
        if (bus.fpu_en) begin
            unitPipe[0] <= unitOp(bus.fpu_a, bus.fpu_b, bus.fpu_sel);
            for (int s = 1; s < L; s++) unitPipe[s] <= unitPipe[s-1];
        end
    end
    assign bus.fpu_r     = unitPipe[L-1][31:0];
    assign bus.fpu_flags = fpu_flags_t'(unitPipe[L-1][36:32]);

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
    } req_t;

    typedef struct {
        int          id;
        logic [31:0] r;
        logic [4:0]  f;
        int          age;
    } pend_t;

    req_t        opQ[$];
    pend_t       pend[$];
    int          rrPtr;
    int          cycleNo;
    int          checkCount;
    int          passCount;
    int          stallCycles;
    bit          lastStall;
    logic [N-1:0] rspReady;

    int          respId[$];
    logic [31:0] respR[$];
    logic [4:0]  respF[$];
    int          respCycle[$];
    int          grantLog[$];
    int          issueCycle[$];

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int frontOf(input int rq);
        for (int k = 0; k < opQ.size(); k++) if (opQ[k].id == rq) return k;
        return -1;
    endfunction

    function automatic int oneHotIdx(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic pushOp(input int id, input logic [31:0] a, input logic [31:0] b, input logic sel);
        req_t r;
        r.id = id; r.a = a; r.b = b; r.sel = sel;
        opQ.push_back(r);
    endtask

    task automatic clearLogs();
        respId.delete(); respR.delete(); respF.delete(); respCycle.delete();
        grantLog.delete(); issueCycle.delete();
        stallCycles = 0;
    endtask

    // One clock cycle: present each requester's oldest op, check all outputs
    // against the reference, then advance the reference past the next edge.
    task automatic applyStimulus();
        int           g;
        int           idx;
        bit           vis;
        bit           stall;
        logic [N-1:0] expReady;
        logic [N-1:0] expRspV;
        pend_t        p;

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            idx = frontOf(i);
            bus.req_valid[i] = (idx >= 0);
            if (idx >= 0) begin
                bus.req_a[i*32 +: 32] = opQ[idx].a;
                bus.req_b[i*32 +: 32] = opQ[idx].b;
                bus.req_sel[i]        = opQ[idx].sel;
            end
        end
        bus.rsp_ready = rspReady;
        #1;

        vis   = (pend.size() > 0) && (pend[0].age == L);
        stall = vis && !rspReady[pend[0].id];
        g = -1;
        if (!stall) begin
            for (int k = 0; k < N; k++) begin
                idx = (rrPtr + k) % N;
                if (g < 0 && frontOf(idx) >= 0) g = idx;
            end
        end
        expReady = (g >= 0) ? N'(1 << g) : '0;
        expRspV  = vis ? N'(1 << pend[0].id) : '0;

        checkOutput("req_ready", 64'(bus.req_ready), 64'(expReady));
        checkOutput("fpu_en",    64'(bus.fpu_en),    64'(!stall));
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(expRspV));
        checkOutput("inflight",  64'(bus.inflight),  64'(pend.size()));
        if (vis) begin
            checkOutput("rsp_r",     64'(bus.rsp_r),     64'(pend[0].r));
            checkOutput("rsp_flags", 64'(bus.rsp_flags), 64'(pend[0].f));
        end

        if (bus.fpu_en === 1'b0) stallCycles++;
        if (bus.req_ready != '0) grantLog.push_back(oneHotIdx(bus.req_ready));
        if ((bus.rsp_valid & rspReady) != '0) begin
            respId.push_back(oneHotIdx(bus.rsp_valid));
            respR.push_back(bus.rsp_r);
            respF.push_back(bus.rsp_flags);
            respCycle.push_back(cycleNo);
        end

        lastStall = stall;
        if (!stall) begin
            if (vis) void'(pend.pop_front());
            foreach (pend[k]) pend[k].age++;
            if (g >= 0) begin
                idx   = frontOf(g);
                p.id  = g;
                {p.f, p.r} = unitOp(opQ[idx].a, opQ[idx].b, opQ[idx].sel);
                p.age = 0;
                pend.push_back(p);
                opQ.delete(idx);
                rrPtr = (g + 1) % N;
                issueCycle.push_back(cycleNo);
            end
        end
        cycleNo++;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((pend.size() > 0 || opQ.size() > 0) && guard < 100) begin
            applyStimulus();
            guard++;
        end
        applyStimulus();
        checkOutput("drain_inflight", 64'(bus.inflight), 64'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        checkOutput({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        checkOutput({tag, "_fpu_a"},     64'(bus.fpu_a),     64'd0);
        checkOutput({tag, "_fpu_b"},     64'(bus.fpu_b),     64'd0);
        checkOutput({tag, "_fpu_sel"},   64'(bus.fpu_sel),   64'd0);
        checkOutput({tag, "_fpu_en"},    64'(bus.fpu_en),    64'd0);
        checkOutput({tag, "_inflight"},  64'(bus.inflight),  64'd0);
    endtask

    initial begin
        int guard;
        checkCount = 0; passCount = 0; cycleNo = 0; rrPtr = 0; lastStall = 0;
        rspReady      = '1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = '1;
        clearLogs();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkResetState("reset");
        @(negedge clk);
        arst = 1'b1;

        // Single multiply 2.0 * 3.0 on requester 0
        clearLogs();
        pushOp(0, 32'h4000_0000, 32'h4040_0000, OP_MUL);
        drain();
        checkOutput("single_count",   64'(respR.size()), 64'd1);
        checkOutput("single_r",       64'(respR[0]), 64'h40C0_0000);
        checkOutput("single_flags",   64'(respF[0]), 64'd0);
        checkOutput("single_id",      64'(respId[0]), 64'd0);
        checkOutput("single_latency", 64'(respCycle[0] - issueCycle[0]), 64'(1 + L));

        // Divide by zero on requester 1
        clearLogs();
        pushOp(1, FP32_ONE, 32'h0000_0000, OP_DIV);
        drain();
        checkOutput("dz_count", 64'(respR.size()), 64'd1);
        checkOutput("dz_r",     64'(respR[0]), 64'(FP32_INF));
        checkOutput("dz_flag",  64'(respF[0][3]), 64'd1);
        checkOutput("dz_id",    64'(respId[0]), 64'd1);

        // Contention: both requesters with two ops each
        clearLogs();
        pushOp(0, 32'h40C0_0000, 32'h4000_0000, OP_DIV);
        pushOp(1, FP32_ONE, FP32_ONE, OP_MUL);
        pushOp(0, 32'h40C0_0000, 32'h4000_0000, OP_DIV);
        pushOp(1, FP32_ONE, FP32_ONE, OP_MUL);
        drain();
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("cont_grant%0d", k), 64'(grantLog[k]), 64'(k % 2));
            checkOutput($sformatf("cont_rid%0d", k),   64'(respId[k]),   64'(k % 2));
            checkOutput($sformatf("cont_r%0d", k),     64'(respR[k]),
                        (k % 2 == 0) ? 64'h4040_0000 : 64'(FP32_ONE));
        end
        checkOutput("cont_back2back", 64'(issueCycle[3] - issueCycle[0]), 64'd3);

        // Back-pressure: requester 1's result blocks the tail for 5 cycles
        clearLogs();
        rspReady[1] = 1'b0;
        pushOp(1, 32'h1234_5678, 32'h0BAD_F00D, OP_MUL);
        applyStimulus();
        pushOp(0, 32'h0000_1111, 32'h2222_0000, OP_DIV);
        pushOp(0, 32'h3333_4444, 32'h5555_6666, OP_MUL);
        guard = 0;
        while (!lastStall && guard < 20) begin
            applyStimulus();
            guard++;
        end
        repeat (4) applyStimulus();
        rspReady[1] = 1'b1;
        drain();
        checkOutput("bp_stall_cycles", 64'(stallCycles), 64'd5);
        checkOutput("bp_count", 64'(respR.size()), 64'd3);
        checkOutput("bp_order0", 64'(respId[0]), 64'd1);
        checkOutput("bp_order1", 64'(respId[1]), 64'd0);
        checkOutput("bp_order2", 64'(respId[2]), 64'd0);

        // Bubbles: requester 0 every other cycle
        clearLogs();
        for (int k = 0; k < 4; k++) begin
            pushOp(0, $urandom, $urandom, 1'($urandom_range(0, 1)));
            applyStimulus();
            applyStimulus();
        end
        drain();
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("bub_lat%0d", k), 64'(respCycle[k] - issueCycle[k]), 64'(1 + L));
        for (int k = 0; k < 3; k++)
            checkOutput($sformatf("bub_gap%0d", k), 64'(respCycle[k+1] - respCycle[k]), 64'd2);

        // Reset with three operations in flight
        pushOp(0, $urandom, $urandom, OP_MUL);
        pushOp(1, $urandom, $urandom, OP_DIV);
        pushOp(0, $urandom, $urandom, OP_MUL);
        guard = 0;
        while (pend.size() < 3 && guard < 20) begin
            applyStimulus();
            guard++;
        end
        checkOutput("mid_inflight", 64'(bus.inflight), 64'd2);
        @(negedge clk);
        #3;
        arst = 1'b0;
        bus.req_valid = '0;
        opQ.delete();
        pend.delete();
        rrPtr = 0;
        #1;
        checkResetState("midreset");
        repeat (2) @(negedge clk);
        arst = 1'b1;
        clearLogs();
        pushOp(1, 32'h4000_0000, 32'h4040_0000, OP_MUL);
        drain();
        checkOutput("post_count",   64'(respR.size()), 64'd1);
        checkOutput("post_r",       64'(respR[0]), 64'h40C0_0000);
        checkOutput("post_latency", 64'(respCycle[0] - issueCycle[0]), 64'(1 + L));

        // Random traffic with random response back-pressure
        clearLogs();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (frontOf(i) < 0 && $urandom_range(0, 99) < 60)
                    pushOp(i, $urandom, ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom,
                           1'($urandom_range(0, 1)));
            end
            for (int i = 0; i < N; i++) rspReady[i] = ($urandom_range(0, 9) != 0);
            applyStimulus();
        end
        rspReady = '1;
        drain();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
